// File: rtl/cavlc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cavlc_ctrl_pkg
//
// Shared types and default parameter values for the CAVLC stage sequencer.
//   ctrl_state_e : sequencer state encoding
//   stage_idx_t  : stage index type for the default stage count
//   DEFAULT_*    : default parameter values used by the sequencer and watchdog
// -----------------------------------------------------------------------------
package cavlc_ctrl_pkg;

  localparam int unsigned DEFAULT_NUM_STAGES = 5;
  localparam int unsigned DEFAULT_SHIFT_W    = 5;
  localparam int unsigned DEFAULT_BLK_CNT_W  = 8;
  localparam int unsigned DEFAULT_TIMEOUT_W  = 10;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    RUN        = 3'd2,
    BLOCK_DONE = 3'd3,
    HALT       = 3'd4,
    ERROR      = 3'd5
  } ctrl_state_e;

  typedef logic [$clog2(DEFAULT_NUM_STAGES)-1:0] stage_idx_t;

endpackage

// File: rtl/cavlc_stage_watchdog.sv
// -----------------------------------------------------------------------------
// cavlc_stage_watchdog
//
// Per-stage RUN timeout counter. The count clears whenever the sequencer is
// not in RUN (so it restarts on every entry to RUN) and advances once per RUN
// cycle.
//
// Ports:
//   clk     : clock, rising edge
//   reset   : synchronous, active-high reset
//   run     : sequencer is in RUN this cycle
//   timeout : this RUN cycle is the terminal one (count reaches all-ones)
// -----------------------------------------------------------------------------
module cavlc_stage_watchdog
  import cavlc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = DEFAULT_TIMEOUT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic timeout
);

  // cnt_q holds the number of RUN cycles already completed in this stage, so
  // the cycle that would carry it to all-ones is the terminal cycle.
  localparam logic [TIMEOUT_W-1:0] TERM_M1 = ~TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = run ? cnt_q + TIMEOUT_W'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = run && (cnt_q == TERM_M1);

endmodule

// File: rtl/cavlc_stage_sequencer.sv
// -----------------------------------------------------------------------------
// cavlc_stage_sequencer
//
// Steps a chain of NUM_STAGES CAVLC sub-decoders once per block and muxes the
// running stage's shift request onto the shared barrel shifter. Supports
// per-block stage skipping, a block-count run limit, abort, and an optional
// per-stage watchdog enabled by defining CTRL_WATCHDOG_EN.
//
// Ports:
//   Clk, Reset            : clock and synchronous active-high reset
//   Enable                : run request
//   BarrelShifterReady    : shifter holds valid bits
//   Abort                 : drop the current block and return to IDLE
//   NumBlocks             : blocks per run, 0 = unlimited
//   StageSkip[k]          : skip stage k (sampled in START of stage k)
//   StageDone[k]          : stage k finished (honoured in RUN of stage k)
//   StageShiftEn/NumShift : per-stage shift requests, slice k = stage k
//   ShiftEn, NumShift     : muxed shift request of the running stage
//   StageStart            : registered one-hot start pulse (first RUN cycle)
//   StageActive           : one-hot running stage
//   BlockDone             : one-cycle pulse per completed block
//   BlockCount            : blocks completed in the current run
//   Busy                  : sequencer not idle
//   Error, ErrorStage     : watchdog fired and the stage that timed out
//
// Without CTRL_WATCHDOG_EN the ERROR state is unreachable, Error and
// ErrorStage stay 0 and TIMEOUT_W has no effect.
// -----------------------------------------------------------------------------
module cavlc_stage_sequencer
  import cavlc_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES = DEFAULT_NUM_STAGES,
  parameter int unsigned SHIFT_W    = DEFAULT_SHIFT_W,
  parameter int unsigned BLK_CNT_W  = DEFAULT_BLK_CNT_W,
  parameter int unsigned TIMEOUT_W  = DEFAULT_TIMEOUT_W
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          Enable,
  input  logic                          BarrelShifterReady,
  input  logic                          Abort,
  input  logic [BLK_CNT_W-1:0]          NumBlocks,
  input  logic [NUM_STAGES-1:0]         StageSkip,
  input  logic [NUM_STAGES-1:0]         StageDone,
  input  logic [NUM_STAGES-1:0]         StageShiftEn,
  input  logic [NUM_STAGES*SHIFT_W-1:0] StageNumShift,
  output logic                          ShiftEn,
  output logic [SHIFT_W-1:0]            NumShift,
  output logic [NUM_STAGES-1:0]         StageStart,
  output logic [NUM_STAGES-1:0]         StageActive,
  output logic                          BlockDone,
  output logic [BLK_CNT_W-1:0]          BlockCount,
  output logic                          Busy,
  output logic                          Error,
  output logic [$clog2(NUM_STAGES)-1:0] ErrorStage
);

  localparam int unsigned     IDX_W    = $clog2(NUM_STAGES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  ctrl_state_e            state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_STAGES-1:0]  stage_start_q, stage_start_d;
  logic [BLK_CNT_W-1:0]   block_count_q, block_count_d;
  logic [IDX_W-1:0]       err_stage_q, err_stage_d;

  logic                   cur_done;
  logic                   cur_skip;
  logic                   cur_shift_en;
  logic [SHIFT_W-1:0]     cur_num_shift;
  logic [NUM_STAGES-1:0]  cur_onehot;
  logic [BLK_CNT_W-1:0]   block_count_inc;
  logic                   last_block;
  logic                   run_active;
  logic                   wdg_timeout;

  // ---------------------------------------------------------------------------
  // Current-stage selection
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    cur_done      = 1'b0;
    cur_skip      = 1'b0;
    cur_shift_en  = 1'b0;
    cur_num_shift = '0;
    cur_onehot    = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_done      = StageDone[i];
        cur_skip      = StageSkip[i];
        cur_shift_en  = StageShiftEn[i];
        cur_num_shift = StageNumShift[i*SHIFT_W +: SHIFT_W];
        cur_onehot[i] = 1'b1;
      end
    end
  end

  // The run limit compares against the count this block will produce.
  assign block_count_inc = block_count_q + BLK_CNT_W'(1);
  assign last_block      = (NumBlocks != '0) && (block_count_inc == NumBlocks);
  assign run_active      = (state_q == RUN);

  // ---------------------------------------------------------------------------
  // Optional watchdog
  // ---------------------------------------------------------------------------
`ifdef CTRL_WATCHDOG_EN
  cavlc_stage_watchdog #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_watchdog (
    .clk     (Clk),
    .reset   (Reset),
    .run     (run_active),
    .timeout (wdg_timeout)
  );
`else
  // Without the watchdog the timeout never fires; TIMEOUT_W has no effect.
  assign wdg_timeout = 1'b0 & (TIMEOUT_W == 0);
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      stage_start_q <= '0;
      block_count_q <= '0;
      err_stage_q   <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      stage_start_q <= stage_start_d;
      block_count_q <= block_count_d;
      err_stage_q   <= err_stage_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    stage_start_d = '0;
    block_count_d = block_count_q;
    err_stage_d   = err_stage_q;

    case (state_q)
      IDLE: begin
        if (Enable && BarrelShifterReady) begin
          state_d       = START;
          idx_d         = '0;
          block_count_d = '0;
        end
      end

      START: begin
        if (Abort) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (cur_skip) begin
          if (idx_q == LAST_IDX) begin
            state_d = BLOCK_DONE;
          end else begin
            state_d = START;
            idx_d   = idx_q + IDX_W'(1);
          end
        end else begin
          // Registered so the pulse lines up with the first RUN cycle.
          state_d       = RUN;
          stage_start_d = cur_onehot;
        end
      end

      RUN: begin
        // Abort outranks completion, and completion on the terminal watchdog
        // cycle outranks the timeout.
        if (Abort) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (cur_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = BLOCK_DONE;
          end else begin
            state_d = START;
            idx_d   = idx_q + IDX_W'(1);
          end
        end else if (wdg_timeout) begin
          state_d     = ERROR;
          err_stage_d = idx_q;
        end
      end

      BLOCK_DONE: begin
        // The BlockDone pulse is visible this cycle, so the count always
        // follows it.
        block_count_d = block_count_inc;
        idx_d         = '0;
        if (Abort) begin
          state_d = IDLE;
        end else if (last_block) begin
          state_d = HALT;
        end else if (!Enable) begin
          state_d = IDLE;
        end else if (BarrelShifterReady) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end

      HALT: begin
        if (Abort || !Enable) begin
          state_d = IDLE;
        end
      end

      ERROR: begin
        if (Abort || !Enable) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ShiftEn     = 1'b0;
    NumShift    = '0;
    StageActive = '0;
    BlockDone   = 1'b0;
    Busy        = (state_q != IDLE);
    Error       = 1'b0;
    ErrorStage  = '0;

    case (state_q)
      RUN: begin
        ShiftEn     = cur_shift_en;
        NumShift    = cur_num_shift;
        StageActive = cur_onehot;
      end
      BLOCK_DONE: begin
        BlockDone = 1'b1;
      end
      ERROR: begin
        Error      = 1'b1;
        ErrorStage = err_stage_q;
      end
      default: begin
      end
    endcase
  end

  assign StageStart = stage_start_q;
  assign BlockCount = block_count_q;

endmodule

// File: tb/tb_cavlc_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cavlc_stage_sequencer
//
// Self-checking bench for cavlc_stage_sequencer (NUM_STAGES=5, TIMEOUT_W=4).
// Expected per-cycle behaviour comes from a schedule built from the stage
// rules: a skipped stage takes one START cycle, a run stage takes START plus
// (1 + delay) RUN cycles, and each block ends in one BLOCK_DONE cycle.
// -----------------------------------------------------------------------------
module tb_cavlc_stage_sequencer;

  localparam int NS  = 5;
  localparam int SW  = 5;
  localparam int BW  = 8;
  localparam int TW  = 4;
  localparam int NSW = NS * SW;

  logic                   Clk;
  logic                   Reset;
  logic                   Enable;
  logic                   BarrelShifterReady;
  logic                   Abort;
  logic [BW-1:0]          NumBlocks;
  logic [NS-1:0]          StageSkip;
  logic [NS-1:0]          StageDone;
  logic [NS-1:0]          StageShiftEn;
  logic [NSW-1:0]         StageNumShift;
  logic                   ShiftEn;
  logic [SW-1:0]          NumShift;
  logic [NS-1:0]          StageStart;
  logic [NS-1:0]          StageActive;
  logic                   BlockDone;
  logic [BW-1:0]          BlockCount;
  logic                   Busy;
  logic                   Error;
  logic [$clog2(NS)-1:0]  ErrorStage;

  int n_assert = 0;
  int n_fail   = 0;

  typedef enum {K_START, K_RUN, K_BDONE} kind_e;
  typedef struct {
    kind_e kind;
    int    stage;
    bit    first;
    bit    done;
    bit    skip;
    int    count;
  } cyc_t;

  cyc_t          sched[$];
  logic [NS-1:0] mask_a [8];
  int            delay_a [8][NS];

  cavlc_stage_sequencer #(
    .NUM_STAGES (NS),
    .SHIFT_W    (SW),
    .BLK_CNT_W  (BW),
    .TIMEOUT_W  (TW)
  ) dut (
    .Clk                (Clk),
    .Reset              (Reset),
    .Enable             (Enable),
    .BarrelShifterReady (BarrelShifterReady),
    .Abort              (Abort),
    .NumBlocks          (NumBlocks),
    .StageSkip          (StageSkip),
    .StageDone          (StageDone),
    .StageShiftEn       (StageShiftEn),
    .StageNumShift      (StageNumShift),
    .ShiftEn            (ShiftEn),
    .NumShift           (NumShift),
    .StageStart         (StageStart),
    .StageActive        (StageActive),
    .BlockDone          (BlockDone),
    .BlockCount         (BlockCount),
    .Busy               (Busy),
    .Error              (Error),
    .ErrorStage         (ErrorStage)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All outputs zero apart from BlockCount, which must equal exp_count.
  task automatic check_quiet(input string tag, input int exp_count);
    check({tag, "_busy"},   32'(Busy),        32'(0));
    check({tag, "_active"}, 32'(StageActive), 32'(0));
    check({tag, "_start"},  32'(StageStart),  32'(0));
    check({tag, "_bdone"},  32'(BlockDone),   32'(0));
    check({tag, "_shen"},   32'(ShiftEn),     32'(0));
    check({tag, "_nshift"}, 32'(NumShift),    32'(0));
    check({tag, "_err"},    32'(Error),       32'(0));
    check({tag, "_errstg"}, 32'(ErrorStage),  32'(0));
    check({tag, "_count"},  32'(BlockCount),  32'(exp_count));
  endtask

  // Expected cycle schedule for nblk back-to-back blocks.
  task automatic build_sched(input int nblk);
    sched.delete();
    for (int b = 0; b < nblk; b++) begin
      for (int k = 0; k < NS; k++) begin
        if (mask_a[b][k]) begin
          sched.push_back('{K_START, k, 1'b0, 1'b0, 1'b1, b});
        end else begin
          sched.push_back('{K_START, k, 1'b0, 1'b0, 1'b0, b});
          for (int j = 0; j <= delay_a[b][k]; j++)
            sched.push_back('{K_RUN, k, (j == 0), (j == delay_a[b][k]), 1'b0, b});
        end
      end
      sched.push_back('{K_BDONE, 0, 1'b0, 1'b0, 1'b0, b});
    end
  endtask

  // Starts from IDLE (cycle 0), follows the schedule, then checks HALT and
  // the return to IDLE once Enable drops.
  task automatic run_sched(input int nblk, output int bdone_cycle, output int pulses);
    cyc_t          e;
    logic [NS-1:0] exp_act;
    logic [NS-1:0] exp_start;
    logic          exp_sen;
    logic [SW-1:0] exp_num;
    int            c;
    bdone_cycle        = -1;
    pulses             = 0;
    NumBlocks          = BW'(nblk);
    Enable             = 1'b1;
    BarrelShifterReady = 1'b1;
    Abort              = 1'b0;
    StageDone          = '0;
    StageSkip          = '0;
    step();
    c = 1;
    for (int i = 0; i < sched.size(); i++) begin
      e         = sched[i];
      StageDone = NS'($urandom);
      StageSkip = NS'($urandom);
      if (e.kind == K_RUN) begin
        StageShiftEn            = NS'($urandom);
        StageNumShift           = NSW'({$urandom, $urandom});
        StageDone[e.stage]      = e.done;
      end else begin
        StageShiftEn  = '1;
        StageNumShift = '1;
        if (e.kind == K_START) StageSkip[e.stage] = e.skip;
      end
      #1;
      exp_act   = '0;
      exp_start = '0;
      exp_sen   = 1'b0;
      exp_num   = '0;
      if (e.kind == K_RUN) begin
        exp_act[e.stage] = 1'b1;
        if (e.first) exp_start[e.stage] = 1'b1;
        exp_sen = StageShiftEn[e.stage];
        exp_num = StageNumShift[e.stage*SW +: SW];
      end
      check("sch_active", 32'(StageActive), 32'(exp_act));
      check("sch_start",  32'(StageStart),  32'(exp_start));
      check("sch_bdone",  32'(BlockDone),   32'(e.kind == K_BDONE));
      check("sch_busy",   32'(Busy),        32'(1));
      check("sch_count",  32'(BlockCount),  32'(e.count));
      check("sch_shen",   32'(ShiftEn),     32'(exp_sen));
      check("sch_nshift", 32'(NumShift),    32'(exp_num));
      check("sch_err",    32'(Error),       32'(0));
      if (BlockDone === 1'b1) begin
        pulses++;
        bdone_cycle = c;
      end
      step();
      c++;
    end
    // HALT: holds while Enable stays high.
    check("halt_busy",   32'(Busy),        32'(1));
    check("halt_active", 32'(StageActive), 32'(0));
    check("halt_bdone",  32'(BlockDone),   32'(0));
    check("halt_count",  32'(BlockCount),  32'(nblk));
    step();
    check("halt_hold",   32'(Busy),        32'(1));
    Enable = 1'b0;
    step();
    check_quiet("halt_exit", nblk);
  endtask

  // Stage 1 never finishes unless done_late, in which case it finishes on
  // the 15th RUN cycle (the terminal cycle for TIMEOUT_W = 4).
  task automatic wdg_run(input bit done_late);
    NumBlocks          = '0;
    StageSkip          = '0;
    StageDone          = '0;
    StageShiftEn       = '0;
    Abort              = 1'b0;
    Enable             = 1'b1;
    BarrelShifterReady = 1'b1;
    step();                       // START(0)
    step();                       // RUN(0)
    StageDone = 5'b00001;
    step();                       // START(1)
    StageDone = '0;
    step();                       // RUN(1), cycle 1
    for (int i = 1; i <= 15; i++) begin
      StageDone = (done_late && i == 15) ? 5'b00010 : 5'b11101;
      #1;
      check("wdg_active", 32'(StageActive), 32'(5'b00010));
      check("wdg_noerr",  32'(Error),       32'(0));
      step();
    end
    StageDone = '0;
    if (done_late) begin
      check("wdg_late_err",    32'(Error),       32'(0));
      check("wdg_late_active", 32'(StageActive), 32'(0));
      check("wdg_late_busy",   32'(Busy),        32'(1));
    end else begin
`ifdef CTRL_WATCHDOG_EN
      check("wdg_err",       32'(Error),       32'(1));
      check("wdg_errstg",    32'(ErrorStage),  32'(1));
      check("wdg_err_act",   32'(StageActive), 32'(0));
      check("wdg_err_busy",  32'(Busy),        32'(1));
      step();
      check("wdg_err_hold",  32'(Error),       32'(1));
      check("wdg_stg_hold",  32'(ErrorStage),  32'(1));
      Enable = 1'b0;
      step();
      check_quiet("wdg_exit", 0);
`else
      check("wdg_off_err",    32'(Error),       32'(0));
      check("wdg_off_active", 32'(StageActive), 32'(5'b00010));
`endif
    end
    Abort  = 1'b1;
    Enable = 1'b0;
    step();
    Abort = 1'b0;
    check_quiet("wdg_done", 0);
  endtask

  initial begin
    int bdc;
    int np;
    int nblk;

    Reset              = 1'b1;
    Enable             = 1'b0;
    BarrelShifterReady = 1'b0;
    Abort              = 1'b0;
    NumBlocks          = '0;
    StageSkip          = '0;
    StageDone          = '0;
    StageShiftEn       = '1;
    StageNumShift      = '1;
    steps(2);
    check_quiet("reset", 0);
    Reset = 1'b0;

    // Plain block: starts at 2,4,6,8,10, BlockDone at 11.
    mask_a[0] = '0;
    for (int k = 0; k < NS; k++) delay_a[0][k] = 0;
    build_sched(1);
    run_sched(1, bdc, np);
    check("basic_bdone_cycle", 32'(bdc), 32'(11));
    check("basic_pulses",      32'(np),  32'(1));

    // Stages 1 and 2 skipped: BlockDone at 9.
    mask_a[0] = 5'b00110;
    build_sched(1);
    run_sched(1, bdc, np);
    check("skip_bdone_cycle", 32'(bdc), 32'(9));

    // Run limit of three blocks.
    for (int b = 0; b < 3; b++) begin
      mask_a[b] = '0;
      for (int k = 0; k < NS; k++) delay_a[b][k] = 0;
    end
    build_sched(3);
    run_sched(3, bdc, np);
    check("limit_pulses", 32'(np), 32'(3));

    // Block 1 fully skipped, block 2 runs stage 2: shift mux, ignored
    // StageDone of another stage, and abort.
    NumBlocks          = '0;
    StageSkip          = 5'b11111;
    StageDone          = '0;
    StageShiftEn       = 5'b00100;
    StageNumShift      = '1;
    Enable             = 1'b1;
    BarrelShifterReady = 1'b1;
    steps(6);                     // cycle 6: BLOCK_DONE
    check("ab_bdone", 32'(BlockDone),  32'(1));
    check("ab_cnt0",  32'(BlockCount), 32'(0));
    StageSkip = 5'b00011;
    step();                       // cycle 7: START(0)
    check("ab_cnt1",  32'(BlockCount), 32'(1));
    check("ab_shen0", 32'(ShiftEn),    32'(0));
    steps(3);                     // cycle 10: RUN(2)
    StageNumShift = NSW'(7) << (2 * SW);
    StageDone     = 5'b00010;
    #1;
    check("ab_shen",   32'(ShiftEn),     32'(1));
    check("ab_nshift", 32'(NumShift),    32'(7));
    check("ab_active", 32'(StageActive), 32'(5'b00100));
    check("ab_start",  32'(StageStart),  32'(5'b00100));
    step();                       // cycle 11: still RUN(2)
    check("ab_ignore", 32'(StageActive), 32'(5'b00100));
    check("ab_start1", 32'(StageStart),  32'(0));
    Abort  = 1'b1;
    Enable = 1'b0;
    step();
    Abort     = 1'b0;
    StageDone = '0;
    check_quiet("abort", 1);

    // BarrelShifterReady low at BLOCK_DONE ends the run.
    StageSkip          = 5'b11111;
    Enable             = 1'b1;
    BarrelShifterReady = 1'b1;
    step();
    check("rdy_cnt_clr", 32'(BlockCount), 32'(0));
    steps(5);
    check("rdy_bdone", 32'(BlockDone), 32'(1));
    BarrelShifterReady = 1'b0;
    step();
    check_quiet("rdy_idle", 1);
    Enable = 1'b0;

    wdg_run(1'b0);
    wdg_run(1'b1);

    // Randomised runs.
    for (int r = 0; r < 4; r++) begin
      nblk = $urandom_range(1, 4);
      for (int b = 0; b < nblk; b++) begin
        mask_a[b] = NS'($urandom);
        for (int k = 0; k < NS; k++) delay_a[b][k] = $urandom_range(0, 3);
      end
      build_sched(nblk);
      run_sched(nblk, bdc, np);
      check("rand_pulses", 32'(np), 32'(nblk));
    end

    // Reset in RUN(3) of the second block.
    NumBlocks          = '0;
    StageSkip          = 5'b11111;
    StageDone          = '0;
    StageShiftEn       = '1;
    Enable             = 1'b1;
    BarrelShifterReady = 1'b1;
    steps(6);                     // cycle 6: BLOCK_DONE
    StageSkip = 5'b00111;
    steps(5);                     // cycle 11: RUN(3)
    check("rst_active", 32'(StageActive), 32'(5'b01000));
    check("rst_start",  32'(StageStart),  32'(5'b01000));
    check("rst_cnt",    32'(BlockCount),  32'(1));
    Reset = 1'b1;
    step();
    check_quiet("rst_mid", 0);
    Reset  = 1'b0;
    Enable = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cavlc_stage_sequencer.md
# cavlc_stage_sequencer

Parametrised control sequencer for the CAVLC decode datapath. It steps a configurable chain of NUM_STAGES sub-decoders (coeff token, trailing ones, level, total zeros, run before, …) once per block, and muxes each stage's shift request onto the shared barrel shifter. Over a fixed-sequence controller it adds per-block stage skipping, a block-count run limit, an abort input and an optional per-stage watchdog. It sits between the bitstream barrel shifter and the per-syntax-element decoders.

## Interface
- NUM_STAGES, 5, number of sequenced decode stages (≥2)
- SHIFT_W, 5, width of shift amount
- BLK_CNT_W, 8, width of block counter / NumBlocks
- TIMEOUT_W, 10, watchdog counter width (used only with CTRL_WATCHDOG_EN)

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  synchronous, active-high reset
- Enable  in  1  run request
- BarrelShifterReady  in  1  shifter holds valid bits
- Abort  in  1  terminate current block, return to IDLE
- NumBlocks  in  BLK_CNT_W  blocks per run; 0 = unlimited
- StageSkip  in  NUM_STAGES  per-stage skip, sampled in START of that stage
- StageDone  in  NUM_STAGES  stage completion, honoured only in RUN for the current stage
- StageShiftEn  in  NUM_STAGES  per-stage shift request
- StageNumShift  in  NUM_STAGES*SHIFT_W  per-stage shift amount, stage i at bits [i*SHIFT_W +: SHIFT_W]
- ShiftEn  out  1  muxed shift enable
- NumShift  out  SHIFT_W  muxed shift amount
- StageStart  out  NUM_STAGES  registered one-hot one-cycle start pulse
- StageActive  out  NUM_STAGES  one-hot, current stage in RUN
- BlockDone  out  1  one-cycle pulse per completed block
- BlockCount  out  BLK_CNT_W  blocks completed in current run
- Busy  out  1  state ≠ IDLE
- Error  out  1  watchdog fired
- ErrorStage  out  $clog2(NUM_STAGES)  stage index that timed out

## Operation
- Reset: state IDLE, stage index 0, every output 0 (including BlockCount, Error, ErrorStage).
- States and transitions:
  - IDLE: Enable & BarrelShifterReady → START, index 0, BlockCount cleared.
  - START(k): StageSkip[k] = 1 → advance (k+1 → START, or last stage → BLOCK_DONE). Otherwise → RUN and StageStart[k] is set for the next cycle.
  - RUN(k): StageDone[k] → advance as in START. Otherwise stay in RUN.
  - BLOCK_DONE: BlockDone = 1 and BlockCount increments, wrapping modulo 2^BLK_CNT_W. Next state:
    - NumBlocks ≠ 0 and BlockCount+1 == NumBlocks → HALT;
    - else !Enable → IDLE;
    - else BarrelShifterReady → START(0);
    - else → IDLE.
  - HALT: stay until Enable = 0, then → IDLE.
  - ERROR: Error = 1, ErrorStage held. → IDLE when Enable = 0 or Abort.
- Abort in any non-IDLE state → IDLE next cycle. Abort outranks StageDone and the watchdog; Reset outranks everything. BlockCount holds its value on Abort.
- ShiftEn/NumShift: in RUN(k) they are StageShiftEn[k] and StageNumShift slice k, combinational and honoured in the Done cycle. In all other states they are 0.
- StageDone for a non-current stage, or outside RUN, is ignored.
- Illegal state encodings → IDLE.

## Timing
- Cycle 0: IDLE with Enable & BarrelShifterReady. Cycle 1: START(0). Cycle 2: RUN(0) with StageStart[0] = 1.
- Stage cost: 2 cycles (START + first RUN cycle) if Done arrives in the first RUN cycle; StageDone is accepted in the same cycle StageStart is high. A skipped stage costs 1 cycle.
- Minimum block latency is 2·NUM_STAGES + 1 cycles. Back-to-back blocks have no gap beyond BLOCK_DONE.
- StageActive, Busy and BlockDone are Moore outputs of the current state. StageStart and BlockCount are registered.

## Configuration
- CTRL_WATCHDOG_EN defined:
  - A TIMEOUT_W counter clears on entry to RUN and increments each RUN cycle.
  - On reaching 2^TIMEOUT_W−1 without StageDone → ERROR, and ErrorStage = k.
  - StageDone on the terminal cycle wins, so no error is raised.
- Not defined: no counter; ERROR is unreachable; Error and ErrorStage are tied to 0; TIMEOUT_W is unused.

## Structure
- Package cavlc_ctrl_pkg holds:
  - the state enum typedef (IDLE, START, RUN, BLOCK_DONE, HALT, ERROR);
  - a stage-index typedef;
  - default parameter constants.
- Sub-module cavlc_stage_watchdog (counter plus terminal compare), instantiated only under CTRL_WATCHDOG_EN.

## Test plan
- NUM_STAGES = 5, no skips, each StageDone asserted on its first RUN cycle: StageStart pulses at cycles 2, 4, 6, 8, 10; BlockDone at cycle 11; BlockCount = 1 at cycle 12.
- StageSkip = 5'b00110: StageStart only for stages 0, 3, 4; BlockDone at cycle 9; no ShiftEn during stages 1 and 2.
- NumBlocks = 3, Enable held high: exactly 3 BlockDone pulses, then HALT with Busy = 1. Dropping Enable → IDLE; Busy = 0 next cycle; BlockCount stays 3.
- RUN(2) with StageShiftEn[2] = 1 and StageNumShift slice 2 = 7: ShiftEn = 1 and NumShift = 7. StageDone[1] asserted during RUN(2) is ignored. Abort in RUN(2) → IDLE next cycle; all outputs 0 except BlockCount.
- CTRL_WATCHDOG_EN, TIMEOUT_W = 4, stage 1 never signals done: Error = 1 and ErrorStage = 1 after 15 RUN cycles. Enable = 0 → IDLE with Error = 0. Done on cycle 15 gives no error.
- Reset asserted mid-RUN(3): next cycle IDLE, all outputs 0.
